pipo_reg: RTL and testbench

// - Parallel-in/parallel-out register: captures a WIDTH-bit word on every rising clock edge and presents it unchanged.
// - Optional extra pipeline stages (STAGES) add alignment delay.
// - Used as a datapath retiming/holding element between combinational blocks; no handshake.
//

---
 rtl/pipo_reg_pkg.sv | 9 +
 rtl/pipo_reg_if.sv | 31 +++
 rtl/pipo_reg_stage.sv | 26 ++
 rtl/pipo_reg.sv | 61 ++++++
 tb/tb_pipo_reg.sv | 106 ++++++++++
 5 files changed

// File: rtl/pipo_reg_pkg.sv
// Shared constants and word type for the parallel-in/parallel-out register.
package pipo_pkg;

    localparam int PIPO_DEFAULT_WIDTH  = 4;
    localparam int PIPO_DEFAULT_STAGES = 1;

    typedef logic [PIPO_DEFAULT_WIDTH-1:0] pipo_word_t;

endpackage : pipo_pkg

// File: rtl/pipo_reg_if.sv
// Data bundle for pipo_reg; parity_out exists only when PIPO_PARITY_EN is defined.
interface pipo_reg_if
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;
`ifdef PIPO_PARITY_EN
    logic             parity_out;
`endif

    // master drives the data word, slave is the register that returns it
    modport master (
        output parallel_in,
`ifdef PIPO_PARITY_EN
        input  parity_out,
`endif
        input  parallel_out
    );

    modport slave (
        input  parallel_in,
`ifdef PIPO_PARITY_EN
        output parity_out,
`endif
        output parallel_out
    );

endinterface : pipo_reg_if

// File: rtl/pipo_reg_stage.sv
// One WIDTH-bit flop bank with asynchronous active-low reset to RESET_VALUE.
module pipo_stage
    import pipo_pkg::*;
#(
    parameter int               WIDTH       = PIPO_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_reg <= RESET_VALUE;
        end else begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : pipo_stage

// File: rtl/pipo_reg.sv
// Parallel-in/parallel-out register with STAGES cascaded flop banks.
// Define PIPO_PARITY_EN to add a registered even-parity output aligned with the data.
module pipo_reg
    import pipo_pkg::*;
#(
    parameter int               WIDTH       = PIPO_DEFAULT_WIDTH,
    parameter int               STAGES      = PIPO_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] parallel_in,
`ifdef PIPO_PARITY_EN
    output logic             parity_out,
`endif
    output logic [WIDTH-1:0] parallel_out
);

    // stage_d[k] feeds stage k; stage_q[k] is its registered output
    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] stage_q [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_d[gi] = parallel_in;
            end else begin : g_chain
                assign stage_d[gi] = stage_q[gi-1];
            end

            pipo_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clock   (clock),
                .reset_n (reset_n),
                .d       (stage_d[gi]),
                .q       (stage_q[gi])
            );
        end
    endgenerate

    assign parallel_out = stage_q[STAGES-1];

`ifdef PIPO_PARITY_EN
    // Parity is computed from the final stage's input so it lands on the same edge as the data.
    logic parity_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            parity_reg <= ^RESET_VALUE;
        end else begin
            parity_reg <= ^stage_d[STAGES-1];
        end
    end

    assign parity_out = parity_reg;
`endif

endmodule : pipo_reg

// File: tb/tb_pipo_reg.sv
// Directed bench for pipo_reg: a STAGES=1 and a STAGES=3 instance on one clock.
`timescale 1ns/1ps
module tb_pipo_reg;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    pipo_reg_if #(.WIDTH(4)) bus1 ();
    pipo_reg_if #(.WIDTH(4)) bus3 ();

    pipo_reg #(.WIDTH(4), .STAGES(1), .RESET_VALUE(4'b0000)) dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .parallel_in  (bus1.parallel_in),
`ifdef PIPO_PARITY_EN
        .parity_out   (bus1.parity_out),
`endif
        .parallel_out (bus1.parallel_out)
    );

    pipo_reg #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'b0000)) dut3 (
        .clock        (clock),
        .reset_n      (reset_n),
        .parallel_in  (bus3.parallel_in),
`ifdef PIPO_PARITY_EN
        .parity_out   (bus3.parity_out),
`endif
        .parallel_out (bus3.parallel_out)
    );

    always #5 clock = ~clock;   // rising edges at 5, 15, 25, ...

    task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    initial begin
        // t=0: reset asserted
        bus1.parallel_in = 4'b0000;
        bus3.parallel_in = 4'b0000;
        #2;  chk("reset_out", bus1.parallel_out, 4'b0000);
`ifdef PIPO_PARITY_EN
        chk("reset_parity", {3'b000, bus1.parity_out}, 4'b0000);
`endif
        #5;  chk("reset_through_edge5", bus1.parallel_out, 4'b0000);          // t=7

        // t=10: release and load sequence
        #3;  reset_n = 1'b1; bus1.parallel_in = 4'b1010; bus3.parallel_in = 4'b1111;
        #2;  chk("no_capture_before_edge", bus1.parallel_out, 4'b0000);       // t=12
        #5;  chk("load_1010", bus1.parallel_out, 4'b1010);                    // t=17
        #3;  bus1.parallel_in = 4'b1100;                                      // t=20
        #7;  chk("load_1100", bus1.parallel_out, 4'b1100);                    // t=27
        #3;  bus1.parallel_in = 4'b0011;                                      // t=30
        #7;  chk("load_0011", bus1.parallel_out, 4'b0011);                    // t=37
        #3;  bus1.parallel_in = 4'b1111;                                      // t=40
        #7;  chk("load_1111", bus1.parallel_out, 4'b1111);                    // t=47
        chk("s3_filled_1111", bus3.parallel_out, 4'b1111);

        // t=50: async reset off-edge
        #3;  reset_n = 1'b0;
        #1;  chk("async_reset_s1", bus1.parallel_out, 4'b0000);               // t=51
        chk("async_reset_s3", bus3.parallel_out, 4'b0000);
        #1;  reset_n = 1'b1; bus3.parallel_in = 4'b0000;                      // t=52
        #5;  chk("recapture_1111", bus1.parallel_out, 4'b1111);               // t=57

        // glitch immunity: toggles between edges, settle to 0101
        #3;  bus1.parallel_in = 4'b0000;                                      // t=60
        #1;  bus1.parallel_in = 4'b1110;
        #1;  bus1.parallel_in = 4'b0001;
        #1;  bus1.parallel_in = 4'b0101;                                      // t=63
        #1;  chk("glitch_invisible", bus1.parallel_out, 4'b1111);             // t=64
        #3;  chk("glitch_settled_0101", bus1.parallel_out, 4'b0101);          // t=67
        #10; chk("hold_0101", bus1.parallel_out, 4'b0101);                    // t=77
        #10; chk("s3_flushed_after_reset", bus3.parallel_out, 4'b0000);       // t=87

        // STAGES=3 pulse: 1001 for one cycle, captured at the 95 ns edge
        #3;  bus3.parallel_in = 4'b1001;                                      // t=90
        #7;  chk("s3_pulse_edge1", bus3.parallel_out, 4'b0000);               // t=97
        #3;  bus3.parallel_in = 4'b0000;                                      // t=100
        #7;  chk("s3_pulse_edge2", bus3.parallel_out, 4'b0000);               // t=107
        #10; chk("s3_pulse_edge3", bus3.parallel_out, 4'b1001);               // t=117
        #10; chk("s3_pulse_gone", bus3.parallel_out, 4'b0000);                // t=127

`ifdef PIPO_PARITY_EN
        #3;  bus1.parallel_in = 4'b0111;                                      // t=130
        #2;  chk("parity_before_edge", {3'b000, bus1.parity_out}, 4'b0000);   // t=132, out still 0101
        #5;  chk("parity_data_0111", bus1.parallel_out, 4'b0111);             // t=137
        chk("parity_0111", {3'b000, bus1.parity_out}, 4'b0001);
        #3;  bus1.parallel_in = 4'b0110;                                      // t=140
        #7;  chk("parity_data_0110", bus1.parallel_out, 4'b0110);             // t=147
        chk("parity_0110", {3'b000, bus1.parity_out}, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipo_reg
